rsa_operand_mover: RTL and testbench

- Design-side engine for the RSA datapath; sits directly behind the Qsys shell.
- Implements the 8-bit control slave (s0) that the shell forwards from Qsys.
- Drives the byte-wide Avalon-MM master (m0) that the shell forwards to Qsys memory.
- Per command: fetches one WORD_BYTES operand block byte by byte, hands it to the RSA core, takes back the result, and writes it byte by byte to the destination block.

---
 rtl/rsa_operand_mover.sv | 195 +++++++++++++++++++
 tb/tb_rsa_operand_mover.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_operand_mover.sv
// Operand/result mover between Avalon-MM memory and the RSA core, controlled via an 8-bit s0 slave.
// Optional build macro RSA_MOVER_BIG_ENDIAN_EN maps byte k to the most-significant end of the operand.
module rsa_operand_mover #(
    parameter int          WORD_BYTES = 32,
    parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
    parameter logic [31:0] DST_BASE   = 32'h0000_1000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    avs_s0_address,
    input  logic                    avs_s0_read,
    input  logic                    avs_s0_write,
    input  logic [7:0]              avs_s0_writedata,
    output logic [7:0]              avs_s0_readdata,
    output logic                    avs_s0_waitrequest,
    output logic [31:0]             avm_m0_address,
    output logic                    avm_m0_read,
    output logic                    avm_m0_write,
    output logic [7:0]              avm_m0_writedata,
    input  logic [7:0]              avm_m0_readdata,
    input  logic                    avm_m0_waitrequest,
    output logic [8*WORD_BYTES-1:0] op_data,
    output logic                    op_valid,
    input  logic                    op_ready,
    input  logic [8*WORD_BYTES-1:0] res_data,
    input  logic                    res_valid,
    output logic                    res_ready
);

    localparam int             KW     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int             DW     = 8 * WORD_BYTES;
    localparam logic [KW-1:0]  K_LAST = KW'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_PRES = 3'd2,
        S_WRES = 3'd3,
        S_WR   = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [7:0]      blk_reg_q, blk_reg_d;
    logic [7:0]      blk_q, blk_d;
    logic            done_q, done_d;
    logic [DW-1:0]   op_q, op_d;
    logic [DW-1:0]   res_q, res_d;

    logic [KW-1:0]   lane_s;
    logic            busy_s;
    logic            start_s;
    logic [31:0]     src_s;
    logic [31:0]     dst_s;

    // Byte lane inside the operand/result word that memory byte k maps to
    function automatic logic [KW-1:0] byte_lane(input logic [KW-1:0] k);
`ifdef RSA_MOVER_BIG_ENDIAN_EN
        byte_lane = K_LAST - k;
`else
        byte_lane = k;
`endif
    endfunction

    assign lane_s  = byte_lane(k_q);
    assign busy_s  = (state_q != S_IDLE) && (state_q != S_FIN);
    assign start_s = avs_s0_write && (avs_s0_address == 1'b0) && avs_s0_writedata[0];
    assign src_s   = SRC_BASE + (32'(blk_q) * 32'(WORD_BYTES)) + 32'(k_q);
    assign dst_s   = DST_BASE + (32'(blk_q) * 32'(WORD_BYTES)) + 32'(k_q);

    assign avs_s0_waitrequest = 1'b0;
    assign avs_s0_readdata    = avs_s0_address ? blk_reg_q : {6'b000000, done_q, busy_s};
    assign op_data            = op_q;

    // Next-state, datapath updates and master/core handshake outputs
    always_comb begin
        state_d          = state_q;
        k_d              = k_q;
        blk_reg_d        = blk_reg_q;
        blk_d            = blk_q;
        done_d           = done_q;
        op_d             = op_q;
        res_d            = res_q;
        avm_m0_address   = 32'h0000_0000;
        avm_m0_read      = 1'b0;
        avm_m0_write     = 1'b0;
        avm_m0_writedata = 8'h00;
        op_valid         = 1'b0;
        res_ready        = 1'b0;

        if (avs_s0_write && (avs_s0_address == 1'b1)) begin
            blk_reg_d = avs_s0_writedata;
        end else begin
            blk_reg_d = blk_reg_q;
        end

        // A status read clears done, but a done set in the same cycle takes priority
        if (state_q == S_FIN) begin
            done_d = 1'b1;
        end else if (avs_s0_read && (avs_s0_address == 1'b0)) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d = S_RD;
                    k_d     = '0;
                    blk_d   = blk_reg_q;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                avm_m0_read    = 1'b1;
                avm_m0_address = src_s;
                if (!avm_m0_waitrequest) begin
                    op_d[{lane_s, 3'b000} +: 8] = avm_m0_readdata;
                    if (k_q == K_LAST) begin
                        state_d = S_PRES;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    k_d = k_q;
                end
            end
            S_PRES: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    state_d = S_WRES;
                end else begin
                    state_d = S_PRES;
                end
            end
            S_WRES: begin
                res_ready = 1'b1;
                if (res_valid) begin
                    res_d   = res_data;
                    k_d     = '0;
                    state_d = S_WR;
                end else begin
                    state_d = S_WRES;
                end
            end
            S_WR: begin
                avm_m0_write     = 1'b1;
                avm_m0_address   = dst_s;
                avm_m0_writedata = res_q[{lane_s, 3'b000} +: 8];
                if (!avm_m0_waitrequest) begin
                    if (k_q == K_LAST) begin
                        state_d = S_FIN;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else begin
                    k_d = k_q;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            blk_reg_q <= 8'h00;
            blk_q     <= 8'h00;
            done_q    <= 1'b0;
            op_q      <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            blk_reg_q <= blk_reg_d;
            blk_q     <= blk_d;
            done_q    <= done_d;
            op_q      <= op_d;
            res_q     <= res_d;
        end
    end

endmodule

// File: tb/tb_rsa_operand_mover.sv
// Scoreboard bench for rsa_operand_mover: randomized memory/core responders, queue-based expectations
// from a byte-level reference model, and a separate monitor that checks every bus and core handshake.
module tb_rsa_operand_mover;

    localparam int          W    = 4;
    localparam int          DW   = 8 * W;
    localparam logic [31:0] SRCB = 32'h0000_0100;
    localparam logic [31:0] DSTB = 32'h0000_0200;

    logic          clk = 1'b0;
    logic          reset;
    logic          avs_s0_address, avs_s0_read, avs_s0_write;
    logic [7:0]    avs_s0_writedata, avs_s0_readdata;
    logic          avs_s0_waitrequest;
    logic [31:0]   avm_m0_address;
    logic          avm_m0_read, avm_m0_write;
    logic [7:0]    avm_m0_writedata, avm_m0_readdata;
    logic          avm_m0_waitrequest;
    logic [DW-1:0] op_data, res_data;
    logic          op_valid, op_ready, res_valid, res_ready;

    always #5 clk = ~clk;

    rsa_operand_mover #(.WORD_BYTES(W), .SRC_BASE(SRCB), .DST_BASE(DSTB)) dut (
        .clk(clk), .reset(reset),
        .avs_s0_address(avs_s0_address), .avs_s0_read(avs_s0_read), .avs_s0_write(avs_s0_write),
        .avs_s0_writedata(avs_s0_writedata), .avs_s0_readdata(avs_s0_readdata),
        .avs_s0_waitrequest(avs_s0_waitrequest),
        .avm_m0_address(avm_m0_address), .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write),
        .avm_m0_writedata(avm_m0_writedata), .avm_m0_readdata(avm_m0_readdata),
        .avm_m0_waitrequest(avm_m0_waitrequest),
        .op_data(op_data), .op_valid(op_valid), .op_ready(op_ready),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready)
    );

    logic [7:0]    mem [0:1023];
    int            n_checks = 0;
    int            n_pass   = 0;
    logic [31:0]   exp_rd[$];
    logic [DW-1:0] exp_op[$];
    int            exp_vlen[$];
    logic [39:0]   exp_wr[$];
    logic [7:0]    exp_rdata[$];
    int            stall_cfg = 0;
    int            rdy_cfg   = 0;
    int            cur_stall = 0;
    int            wcnt      = 0;
    int            rdy_cnt   = 0;
    logic [DW-1:0] cur_res   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int pick_stall();
        return (stall_cfg >= 0) ? stall_cfg : int'($urandom_range(0, 2));
    endfunction

    // Reference: operand is the W source bytes placed by the endianness rule
    function automatic logic [DW-1:0] model_op(input logic [31:0] base);
        logic [DW-1:0] v = '0;
        for (int i = 0; i < W; i++) begin
`ifdef RSA_MOVER_BIG_ENDIAN_EN
            v = v | (DW'(mem[10'(base + 32'(i))]) << (8 * (W - 1 - i)));
`else
            v = v | (DW'(mem[10'(base + 32'(i))]) << (8 * i));
`endif
        end
        return v;
    endfunction

    function automatic logic [7:0] model_byte(input logic [DW-1:0] r, input int i);
        logic [DW-1:0] s;
`ifdef RSA_MOVER_BIG_ENDIAN_EN
        s = r >> (8 * (W - 1 - i));
`else
        s = r >> (8 * i);
`endif
        return s[7:0];
    endfunction

    // Memory slave and RSA core responder, driven on the falling edge
    always @(negedge clk) begin
        if (reset && (avm_m0_read || avm_m0_write)) begin
            if (wcnt < cur_stall) begin
                avm_m0_waitrequest = 1'b1;
                wcnt++;
            end else begin
                avm_m0_waitrequest = 1'b0;
                wcnt = 0;
                cur_stall = pick_stall();
            end
        end else begin
            avm_m0_waitrequest = 1'b0;
            wcnt = 0;
            cur_stall = pick_stall();
        end
        avm_m0_readdata = (avm_m0_read && !avm_m0_waitrequest) ? mem[avm_m0_address[9:0]] : 8'($urandom);
        if (op_valid) begin
            if (rdy_cnt == 0) op_ready = 1'b1;
            else begin
                op_ready = 1'b0;
                rdy_cnt--;
            end
        end else begin
            op_ready = 1'b0;
            rdy_cnt = rdy_cfg;
        end
        res_valid = res_ready;
        res_data  = res_ready ? cur_res : DW'($urandom);
    end

    int          vcnt = 0;
    logic        prev_stall = 1'b0;
    logic [41:0] prev_bus = '0;

    // Monitor: pops the scoreboard whenever the DUT completes a transfer or handshake
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            vcnt = 0;
            prev_stall = 1'b0;
        end else begin
            check("rd_wr_exclusive", 64'(avm_m0_read & avm_m0_write), 64'd0);
            if (prev_stall)
                check("stall_hold", 64'({avm_m0_read, avm_m0_write, avm_m0_address, avm_m0_writedata}),
                      64'(prev_bus));
            if (avm_m0_read && !avm_m0_waitrequest) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_read: address %h, expected no read", avm_m0_address);
                end else check("rd_addr", 64'(avm_m0_address), 64'(exp_rd.pop_front()));
            end
            if (avm_m0_write && !avm_m0_waitrequest) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: address %h, expected no write", avm_m0_address);
                end else check("wr_addr_data", 64'({avm_m0_address, avm_m0_writedata}), 64'(exp_wr.pop_front()));
            end
            if (op_valid) begin
                vcnt++;
                if (op_ready) begin
                    if (exp_op.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_op: op_data %h, expected no operand", op_data);
                    end else begin
                        check("op_data", 64'(op_data), 64'(exp_op.pop_front()));
                        check("op_valid_len", 64'(vcnt), 64'(exp_vlen.pop_front()));
                    end
                    vcnt = 0;
                end
            end
            if (avs_s0_read) begin
                if (exp_rdata.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_s0_read: readdata %h", avs_s0_readdata);
                end else check("s0_readdata", 64'(avs_s0_readdata), 64'(exp_rdata.pop_front()));
            end
            prev_stall = (avm_m0_read || avm_m0_write) && avm_m0_waitrequest;
            prev_bus   = {avm_m0_read, avm_m0_write, avm_m0_address, avm_m0_writedata};
        end
    end

    task automatic s0_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        avs_s0_address = a; avs_s0_writedata = d; avs_s0_write = 1'b1;
        @(negedge clk);
        avs_s0_write = 1'b0;
    endtask

    task automatic s0_read(input logic a, input logic [7:0] exp);
        @(negedge clk);
        exp_rdata.push_back(exp);
        avs_s0_address = a; avs_s0_read = 1'b1;
        @(negedge clk);
        avs_s0_read = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] blk, input int stall, input int rdy,
                          input logic [DW-1:0] res, input bit disturb);
        logic [31:0] src, dst;
        int t;
        stall_cfg = stall; rdy_cfg = rdy; cur_res = res;
        s0_write(1'b1, blk);
        s0_read(1'b1, blk);
        src = SRCB + 32'(blk) * 32'(W);
        dst = DSTB + 32'(blk) * 32'(W);
        for (int i = 0; i < W; i++) exp_rd.push_back(src + 32'(i));
        exp_op.push_back(model_op(src));
        exp_vlen.push_back(rdy + 1);
        for (int i = 0; i < W; i++) exp_wr.push_back({dst + 32'(i), model_byte(res, i)});
        s0_write(1'b0, 8'h01);
        if (disturb) begin
            s0_write(1'b0, 8'h01);
            s0_write(1'b1, 8'h05);
            s0_read(1'b1, 8'h05);
            s0_read(1'b0, 8'h01);
        end
        t = 0;
        while (exp_wr.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("op_completes", 64'(exp_wr.size()), 64'd0);
        repeat (3) @(negedge clk);
        s0_read(1'b0, 8'h02);
        s0_read(1'b0, 8'h00);
        check("rd_queue_empty", 64'(exp_rd.size()), 64'd0);
        check("op_queue_empty", 64'(exp_op.size()), 64'd0);
        exp_rd.delete(); exp_op.delete(); exp_vlen.delete(); exp_wr.delete();
    endtask

    initial begin
        int t;
        reset = 1'b0;
        avs_s0_address = 1'b0; avs_s0_read = 1'b0; avs_s0_write = 1'b0; avs_s0_writedata = 8'h00;
        avm_m0_waitrequest = 1'b0; avm_m0_readdata = 8'h00;
        op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        check("rst_read",   64'(avm_m0_read),     64'd0);
        check("rst_write",  64'(avm_m0_write),    64'd0);
        check("rst_addr",   64'(avm_m0_address),  64'd0);
        check("rst_opv",    64'(op_valid),        64'd0);
        check("rst_resrdy", 64'(res_ready),       64'd0);
        check("rst_opdata", 64'(op_data),         64'd0);
        check("rst_status", 64'(avs_s0_readdata), 64'd0);
        check("rst_wait",   64'(avs_s0_waitrequest), 64'd0);
        reset = 1'b1;

        mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
        run_op(8'd0, 0, 0, DW'($urandom), 1'b0);
        run_op(8'd0, 3, 0, DW'($urandom), 1'b0);
        run_op(8'd0, 0, 10, 32'hDEADBEEF, 1'b0);
        run_op(8'd2, 0, 0, DW'($urandom), 1'b0);
        run_op(8'd1, 1, 2, DW'($urandom), 1'b1);

        for (int n = 0; n < 16; n++) begin
            for (int a = 16'h100; a < 16'h140; a++) mem[a] = 8'($urandom);
            run_op(8'($urandom_range(0, 15)), -1, int'($urandom_range(0, 4)), DW'($urandom), 1'b0);
        end

        // Abort in the middle of the read phase
        stall_cfg = 3;
        s0_write(1'b1, 8'd1);
        for (int i = 0; i < W; i++) exp_rd.push_back(SRCB + 32'(W) + 32'(i));
        s0_write(1'b0, 8'h01);
        t = 0;
        while (!avm_m0_read && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("abort_in_rd", 64'(avm_m0_read), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_read",  64'(avm_m0_read),  64'd0);
        check("abort_write", 64'(avm_m0_write), 64'd0);
        check("abort_opv",   64'(op_valid),     64'd0);
        reset = 1'b1;
        exp_rd.delete();
        s0_read(1'b0, 8'h00);
        s0_read(1'b1, 8'h00);
        run_op(8'd3, -1, 1, DW'($urandom), 1'b0);

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
